// File: rtl/spi_txn_arbiter_if.sv
// Requester-side bus of the SPI transaction arbiter:
// request level, per-requester cfg/data, grant pulse and response.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32
) ();
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*6-1:0]          req_cfg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          rsp_valid;
  logic [1:0]                    rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          busy;

  modport master (
    output req, req_cfg, req_data,
    input  grant, rsp_valid, rsp_id,
    input  rsp_data, rsp_err, busy
  );

  modport slave (
    input  req, req_cfg, req_data,
    output grant, rsp_valid, rsp_id,
    output rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one
// SPI master between requesters; all outputs registered.
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  spi_txn_arbiter_if.slave      bus,
  output logic [8:0]            SPI_CTRL,
  output logic [DATA_WIDTH-1:0] SPI_DATA_OUT,
  input  logic [DATA_WIDTH-1:0] SPI_DATA_IN,
  input  logic                  done,
  output logic                  spi_abort
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FRAME, START, WAIT, RESP, ABORT
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            cfg_q, cfg_d;
  logic [1:0]            win_q, win_d;
  logic [1:0]            rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  st2_q, st2_d;
  logic                  done_d1_q;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  rv_q, rv_d;
  logic [1:0]            rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  rerr_q, rerr_d;
  logic                  busy_q, busy_d;
  logic [8:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  abort_q, abort_d;

  logic       found;
  logic [1:0] pick;
  logic       done_edge;
  logic [5:0] pick_cfg;

  assign done_edge = done & ~done_d1_q;
  assign pick_cfg  = bus.req_cfg[6*int'(pick) +: 6];

  // {ON, MODE, BIT_ORDER, LEN, FRAME_START, START, I_MSK}
  function automatic logic [8:0] ctrl_f(
    input logic [5:0] c,
    input logic       fs,
    input logic       st
  );
    return {1'b1, c[5:1], fs, st, c[0]};
  endfunction

  // First set request at or above rr pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = 2'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    win_d   = win_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    st2_d   = 1'b0;
    grant_d = '0;
    rv_d    = 1'b0;
    rid_d   = rid_q;
    rdat_d  = rdat_q;
    rerr_d  = 1'b0;
    ctrl_d  = ctrl_q;
    dout_d  = dout_q;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        ctrl_d = '0;
        if (found) begin
          state_d = FRAME;
          win_d   = pick;
          grant_d = NUM_REQ'(1) << pick;
          cfg_d   = pick_cfg;
          dout_d  = bus.req_data[DATA_WIDTH*int'(pick) +: DATA_WIDTH];
          rr_d    = (pick == 2'(NUM_REQ - 1)) ? 2'd0 : pick + 2'd1;
          ctrl_d  = ctrl_f(pick_cfg, 1'b1, 1'b0);
        end
      end
      FRAME: begin
        state_d = START;
        cnt_d   = '0;
        ctrl_d  = ctrl_f(cfg_q, 1'b0, 1'b1);
      end
      START: begin
        cnt_d = '0;
        if (st2_q) begin
          state_d = WAIT;
          ctrl_d  = ctrl_f(cfg_q, 1'b0, 1'b0);
        end else begin
          st2_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done edge in the expiry cycle still counts as success
        if (done_edge) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rid_d   = win_q;
          rdat_d  = SPI_DATA_IN;
          ctrl_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ABORT;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          rid_d   = win_q;
          rdat_d  = '0;
          abort_d = 1'b1;
          ctrl_d  = '0;
        end
      end
      RESP, ABORT: begin
        state_d = IDLE;
        ctrl_d  = '0;
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      win_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      st2_q     <= 1'b0;
      done_d1_q <= 1'b0;
      grant_q   <= '0;
      rv_q      <= 1'b0;
      rid_q     <= '0;
      rdat_q    <= '0;
      rerr_q    <= 1'b0;
      busy_q    <= 1'b0;
      ctrl_q    <= '0;
      dout_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      st2_q     <= st2_d;
      done_d1_q <= done;
      grant_q   <= grant_d;
      rv_q      <= rv_d;
      rid_q     <= rid_d;
      rdat_q    <= rdat_d;
      rerr_q    <= rerr_d;
      busy_q    <= busy_d;
      ctrl_q    <= ctrl_d;
      dout_q    <= dout_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_data  = rdat_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.busy      = busy_q;
  assign SPI_CTRL      = ctrl_q;
  assign SPI_DATA_OUT  = dout_q;
  assign spi_abort     = abort_q;

endmodule
